// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer and the core: fetch handshake, decode fields,
// execute completion, halt request and the PC register load port.
interface pc_sequencer_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] pc;
  logic                imem_req;
  logic                imem_ready;
  logic                dec_valid;
  logic                is_branch;
  logic                br_taken;
  logic                is_jump;
  logic                is_jr;
  logic [15:0]         imm16;
  logic [25:0]         jtarget26;
  logic [PC_WIDTH-1:0] rs_val;
  logic                exec_done;
  logic                halt_req;
  logic                pc_en;
  logic [PC_WIDTH-1:0] next_pc;
  logic                halted;
  logic                misalign_err;

  modport master (
    input  pc, imem_ready, dec_valid, is_branch, br_taken, is_jump, is_jr,
           imm16, jtarget26, rs_val, exec_done, halt_req,
    output imem_req, pc_en, next_pc, halted, misalign_err
  );

  modport slave (
    output pc, imem_ready, dec_valid, is_branch, br_taken, is_jump, is_jr,
           imm16, jtarget26, rs_val, exec_done, halt_req,
    input  imem_req, pc_en, next_pc, halted, misalign_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: BOOT/FETCH/DECODE/EXEC/UPDATE/HALT, one pc_en pulse per instruction,
// fetch and execute latency unbounded. PC_SEQ_RETIRE_CNT_EN adds the retired_cnt output.
module pc_sequencer #(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst,
`ifdef PC_SEQ_RETIRE_CNT_EN
  output logic [31:0]        retired_cnt,
`endif
  pc_sequencer_if.master     bus
);

  typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXEC, UPDATE, HALT} state_t;

  state_t              state_q, state_d;
  logic                halt_seen_q, halt_seen_d;
  logic                misalign_q, misalign_d;
  logic                is_branch_q, is_branch_d;
  logic                is_jump_q, is_jump_d;
  logic                is_jr_q, is_jr_d;
  logic [15:0]         imm16_q, imm16_d;
  logic [25:0]         jtarget26_q, jtarget26_d;
  logic [PC_WIDTH-1:0] rs_val_q, rs_val_d;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic [PC_WIDTH-1:0] next_pc_q;

  logic                pc_en_c;
  logic                imem_req_c;
  logic                halted_c;
  logic [PC_WIDTH-1:0] npc_c;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] tgt;

  assign pc_plus4 = bus.pc + PC_WIDTH'(4);

  always_comb begin
    if (is_jr_q)
      tgt = rs_val_q;
    else if (is_jump_q)
      tgt = {pc_plus4[PC_WIDTH-1:28], jtarget26_q, 2'b00};
    else if (is_branch_q && bus.br_taken)
      tgt = pc_plus4 + {{(PC_WIDTH-18){imm16_q[15]}}, imm16_q, 2'b00};
    else
      tgt = pc_plus4;
  end

  always_comb begin
    state_d     = state_q;
    halt_seen_d = halt_seen_q;
    misalign_d  = misalign_q;
    is_branch_d = is_branch_q;
    is_jump_d   = is_jump_q;
    is_jr_d     = is_jr_q;
    imm16_d     = imm16_q;
    jtarget26_d = jtarget26_q;
    rs_val_d    = rs_val_q;
    target_d    = target_q;
    pc_en_c     = 1'b0;
    imem_req_c  = 1'b0;
    halted_c    = 1'b0;
    npc_c       = next_pc_q;
    case (state_q)
      BOOT: begin
        pc_en_c     = 1'b1;
        npc_c       = RESET_VECTOR;
        halt_seen_d = 1'b0;
        state_d     = FETCH;
      end
      FETCH: begin
        imem_req_c  = 1'b1;
        halt_seen_d = halt_seen_q | bus.halt_req;
        if (bus.imem_ready) state_d = DECODE;
      end
      DECODE: begin
        halt_seen_d = halt_seen_q | bus.halt_req;
        if (bus.dec_valid) begin
          is_branch_d = bus.is_branch;
          is_jump_d   = bus.is_jump;
          is_jr_d     = bus.is_jr;
          imm16_d     = bus.imm16;
          jtarget26_d = bus.jtarget26;
          rs_val_d    = bus.rs_val;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        halt_seen_d = halt_seen_q | bus.halt_req;
        if (bus.exec_done) begin
          target_d = tgt;
          // Only a JR target can land off a word boundary; abort without loading the PC.
          if (tgt[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        pc_en_c     = 1'b1;
        npc_c       = target_q;
        halt_seen_d = 1'b0;
        state_d     = (halt_seen_q || bus.halt_req) ? HALT : FETCH;
      end
      HALT: begin
        halted_c = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      halt_seen_q <= 1'b0;
      misalign_q  <= 1'b0;
      is_branch_q <= 1'b0;
      is_jump_q   <= 1'b0;
      is_jr_q     <= 1'b0;
      imm16_q     <= '0;
      jtarget26_q <= '0;
      rs_val_q    <= '0;
      target_q    <= '0;
      next_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      halt_seen_q <= halt_seen_d;
      misalign_q  <= misalign_d;
      is_branch_q <= is_branch_d;
      is_jump_q   <= is_jump_d;
      is_jr_q     <= is_jr_d;
      imm16_q     <= imm16_d;
      jtarget26_q <= jtarget26_d;
      rs_val_q    <= rs_val_d;
      target_q    <= target_d;
      if (pc_en_c) next_pc_q <= npc_c;
    end
  end

`ifdef PC_SEQ_RETIRE_CNT_EN
  logic [31:0] retired_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retired_cnt_q <= '0;
    else if (state_q == UPDATE)
      retired_cnt_q <= retired_cnt_q + 32'd1;
  end

  assign retired_cnt = retired_cnt_q;
`endif

  // State sits in BOOT while rst is high, so the BOOT load must be masked until release.
  assign bus.pc_en        = pc_en_c & ~rst;
  assign bus.next_pc      = rst ? '0 : npc_c;
  assign bus.imem_req     = imem_req_c;
  assign bus.halted       = halted_c;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected next_pc values are queued as each
// instruction is driven and popped whenever the DUT pulses pc_en.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] exp_q[$];

`ifdef PC_SEQ_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  pc_sequencer_if #(.PC_WIDTH(32)) bus();

  pc_sequencer #(.PC_WIDTH(32), .RESET_VECTOR(RV)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef PC_SEQ_RETIRE_CNT_EN
    .retired_cnt (retired_cnt),
`endif
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every pc_en pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.pc_en) begin
      if (exp_q.size() == 0) chk("pc_en_unexpected", bus.pc_en, 1'b0);
      else                   chk("next_pc", bus.next_pc, exp_q.pop_front());
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, bus.imem_req, 1'b0);
    chk({tag, "_pc_en"}, bus.pc_en, 1'b0);
    chk({tag, "_next_pc"}, bus.next_pc, 32'h0);
    chk({tag, "_halted"}, bus.halted, 1'b0);
    chk({tag, "_misalign"}, bus.misalign_err, 1'b0);
  endtask

  // Leaves the DUT in FETCH, one time unit after the edge.
  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dec_valid  = 1'b0;
    bus.exec_done  = 1'b0;
    bus.halt_req   = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("rst");
    exp_q.push_back(RV);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [31:0] pc_v, input logic br, input logic tk,
                           input logic jmp, input logic jr, input logic [15:0] imm,
                           input logic [25:0] jt, input logic [31:0] rs, input int lat,
                           input logic halt_dec, input logic exp_fault,
                           input logic [31:0] exp_pc);
    bus.pc = pc_v;
    for (int i = 0; i < lat; i++) begin
      chk("imem_req_wait", bus.imem_req, 1'b1);
      @(posedge clk); #1;
    end
    chk("imem_req_rdy", bus.imem_req, 1'b1);
    bus.imem_ready = 1'b1;
    @(posedge clk); #1;
    bus.imem_ready = 1'b0;
    chk("imem_req_dec", bus.imem_req, 1'b0);
    bus.halt_req  = halt_dec;
    bus.is_branch = br;
    bus.is_jump   = jmp;
    bus.is_jr     = jr;
    bus.imm16     = imm;
    bus.jtarget26 = jt;
    bus.rs_val    = rs;
    @(posedge clk); #1;
    bus.halt_req  = 1'b0;
    bus.dec_valid = 1'b1;
    @(posedge clk); #1;
    bus.dec_valid = 1'b0;
    bus.is_branch = 1'b0;
    bus.is_jump   = 1'b0;
    bus.is_jr     = 1'b0;
    bus.imm16     = ~imm;
    bus.jtarget26 = ~jt;
    bus.rs_val    = ~rs;
    bus.br_taken  = ~tk;
    @(posedge clk); #1;
    bus.br_taken  = tk;
    bus.exec_done = 1'b1;
    if (!exp_fault) exp_q.push_back(exp_pc);
    @(posedge clk); #1;
    bus.exec_done = 1'b0;
    bus.br_taken  = 1'b0;
    if (exp_fault) begin
      chk("fault_halted", bus.halted, 1'b1);
      chk("fault_misalign", bus.misalign_err, 1'b1);
      chk("fault_imem_req", bus.imem_req, 1'b0);
    end else begin
      @(posedge clk); #1;
      chk("next_pc_hold", bus.next_pc, exp_pc);
      chk("misalign_clear", bus.misalign_err, 1'b0);
      if (halt_dec) begin
        chk("halt_after_update", bus.halted, 1'b1);
        chk("halt_imem_req", bus.imem_req, 1'b0);
      end else begin
        chk("refetch_req", bus.imem_req, 1'b1);
      end
    end
  endtask

  initial begin
    bus.pc = RV; bus.imem_ready = 1'b0; bus.dec_valid = 1'b0;
    bus.is_branch = 1'b0; bus.br_taken = 1'b0; bus.is_jump = 1'b0; bus.is_jr = 1'b0;
    bus.imm16 = '0; bus.jtarget26 = '0; bus.rs_val = '0;
    bus.exec_done = 1'b0; bus.halt_req = 1'b0;

    do_reset();
    run_instr(RV, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 3, 0, 0, RV + 32'd4);
    run_instr(32'h100, 1, 1, 0, 0, 16'hFFFF, 26'h0, 32'h0, 0, 0, 0, 32'h100);
    run_instr(32'h100, 1, 0, 0, 0, 16'hFFFF, 26'h0, 32'h0, 1, 0, 0, 32'h104);
    run_instr(32'h200, 1, 1, 0, 0, 16'h0010, 26'h0, 32'h0, 0, 0, 0, 32'h244);
    run_instr(32'h1000_0000, 0, 0, 1, 0, 16'h0, 26'h3FF_FFFF, 32'h0, 2, 0, 0, 32'h1FFF_FFFC);
    run_instr(32'h500, 1, 1, 1, 1, 16'h0004, 26'h155, 32'h2000, 0, 0, 0, 32'h2000);
    run_instr(32'hFFFF_FFFC, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0, 0, 32'h0);
    run_instr(32'h2000, 0, 0, 0, 1, 16'h0, 26'h0, 32'h2002, 0, 0, 1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("halt_sticky", bus.halted, 1'b1);
      chk("misalign_sticky", bus.misalign_err, 1'b1);
      chk("halt_no_req", bus.imem_req, 1'b0);
    end

    do_reset();
    run_instr(RV, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 1, 0, RV + 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("halt_req_stays", bus.halted, 1'b1);
      chk("halt_req_no_req", bus.imem_req, 1'b0);
    end

    do_reset();
    bus.pc = RV;
    repeat (2) begin
      @(posedge clk); #1;
      chk("fetch_wait_req", bus.imem_req, 1'b1);
    end
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_fetch");
    do_reset();
    run_instr(RV, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 0, 0, RV + 32'd4);

`ifdef PC_SEQ_RETIRE_CNT_EN
    do_reset();
    chk("retired_reset", retired_cnt, 32'd0);
    for (int i = 0; i < 5; i++)
      run_instr(RV + 32'(4 * i), 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, i % 2, 0, 0,
                RV + 32'(4 * i) + 32'd4);
    chk("retired_five", retired_cnt, 32'd5);
    run_instr(32'h3000, 0, 0, 0, 1, 16'h0, 26'h0, 32'h3001, 0, 0, 1, 32'h0);
    chk("retired_no_abort", retired_cnt, 32'd5);
`endif

    @(posedge clk); #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control block that sequences the program counter register of the non-pipelined MIPS core.
- Runs the fetch handshake with instruction memory and waits for decode and execute completion.
- Selects the next PC: sequential, branch, jump or jump-register.
- Drives the PC register's enable and next-PC inputs, and handles halt and misaligned-target fault.

Parameters:
- PC_WIDTH, 32, PC width in bits; legal range 32..64.
- RESET_VECTOR, 32'h0000_0000, first fetch address loaded into the PC after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- pc  input  PC_WIDTH  current value from PC register
- imem_req  output  1  instruction fetch request; address is pc
- imem_ready  input  1  fetch complete; instruction captured externally this cycle
- dec_valid  input  1  decode fields below are valid
- is_branch  input  1  conditional branch
- br_taken  input  1  branch condition true; sampled with exec_done
- is_jump  input  1  J/JAL
- is_jr  input  1  JR/JALR
- imm16  input  16  branch offset, in words
- jtarget26  input  26  jump index
- rs_val  input  PC_WIDTH  register target for JR
- exec_done  input  1  execute/memory/writeback phases finished
- halt_req  input  1  stop after the current instruction
- pc_en  output  1  PC register load enable
- next_pc  output  PC_WIDTH  value to load
- halted  output  1  sequencer in HALT
- misalign_err  output  1  sticky misaligned-target fault

Behaviour:
- Reset (async, rst=1):
  - state=BOOT.
  - All outputs are 0: imem_req, pc_en, next_pc, halted, misalign_err.
  - Reset mid-operation aborts everything immediately. No outstanding request is remembered.
- BOOT: one cycle, pc_en=1 and next_pc=RESET_VECTOR, then go to FETCH.
- FETCH:
  - imem_req=1 held continuously until imem_ready=1.
  - On imem_ready go to DECODE. Fetch latency is unbounded.
- DECODE: wait for dec_valid=1. Latch is_branch, is_jump, is_jr, imm16, jtarget26 and rs_val, then go to EXEC.
- EXEC: wait for exec_done=1. Sample br_taken, compute the target, then go to UPDATE.
- UPDATE: pc_en=1 for exactly one cycle with next_pc=target.
  - If halt_req was seen at any cycle since FETCH entry, go to HALT.
  - Otherwise go to FETCH.
- Target computation, with all additions modulo 2^PC_WIDTH and pc_plus4 = pc + 4:
  - Priority 1, is_jr: target = rs_val.
  - Priority 2, is_jump: target = {pc_plus4[PC_WIDTH-1:28], jtarget26, 2'b00}.
  - Priority 3, is_branch and br_taken: target = pc_plus4 + (sign-extended imm16 << 2).
  - Otherwise: target = pc_plus4.
- Misaligned target: if target[1:0] != 0 (possible only for JR), there is no pc_en pulse. Set misalign_err=1 and go to HALT.
- HALT:
  - halted=1; pc_en=0 and imem_req=0.
  - Leave only via rst.
  - misalign_err stays 1 until rst.
- pc_en is never asserted outside BOOT and UPDATE; at most one pulse per instruction.
- next_pc holds its last driven value when pc_en=0.
- Wrap-around: pc=32'hFFFF_FFFC sequential gives next_pc=0. No fault is raised.

Optional Feature:
- Macro PC_SEQ_RETIRE_CNT_EN.
- Defined:
  - Adds output retired_cnt, 32 bits, reset to 0.
  - Increments on every UPDATE pc_en pulse; wraps at 2^32.
  - The BOOT pulse and misaligned aborts are not counted.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset boot, RESET_VECTOR=32'h0040_0000, imem_ready 3 cycles late, sequential instruction:
  - pc_en with next_pc=32'h0040_0000 in the first cycle after rst.
  - imem_req held 3 cycles.
  - UPDATE gives next_pc=32'h0040_0004.
- Branch at pc=32'h100, imm16=16'hFFFF, br_taken=1 -> next_pc=32'h100. With br_taken=0 -> next_pc=32'h104.
- pc=32'h1000_0000, is_jump=1, jtarget26=26'h3FF_FFFF -> next_pc=32'h1FFF_FFFC.
- is_jr=1 and is_jump=1 with rs_val=32'h2000 -> next_pc=32'h2000.
  - Then rs_val=32'h2002 -> no pc_en, misalign_err=1, halted=1, imem_req stays 0.
- halt_req pulsed one cycle during DECODE:
  - UPDATE completes with next_pc=pc+4, then halted=1.
  - rst during a FETCH wait returns to BOOT, all outputs 0.
- With PC_SEQ_RETIRE_CNT_EN, 5 instructions executed -> retired_cnt=5 (BOOT not counted).
